// File: rtl/comparator_seq_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared types and helpers for the sequential magnitude comparator.
//   cmp_state_t  : controller states (IDLE -> CMP -> DONE -> IDLE)
//   cmp_result_t : encoded compare outcome, decoded to one-hot flags at the top
//   cnt_width()  : width of the slice counter, never less than one bit
// -----------------------------------------------------------------------------
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } cmp_state_t;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_EQ = 2'b01,
        CMP_GT = 2'b10
    } cmp_result_t;

    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/comparator_seq_slice.sv
// -----------------------------------------------------------------------------
// cmp_slice
// Purely combinational unsigned compare of one CHUNK-bit slice.
//   a, b : slice operands (any sign handling is applied by the caller)
//   gt   : a > b
//   eq   : a == b
// -----------------------------------------------------------------------------
module cmp_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq
);

    always_comb begin
        gt = (a > b);
        eq = (a == b);
    end

endmodule

// File: rtl/comparator_seq.sv
// -----------------------------------------------------------------------------
// comparator_seq
// Multi-cycle WIDTH-bit magnitude comparator, MSB-first, CHUNK bits per cycle,
// unsigned or two's-complement per transaction.
//
// Ports:
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (A, B, is_signed captured)
//   out_valid / out_ready : result handshake
//   A_gt_B/A_eq_B/A_lt_B  : one-hot result, held until the next result
//   busy                  : high while comparing or holding a result
//
// Build option:
//   CMP_EARLY_EXIT_EN     : leave CMP on the first unequal slice instead of
//                           always spending NSLICE cycles (results identical)
// -----------------------------------------------------------------------------
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             busy
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NSLICE);

    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("comparator_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    cmp_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic            signed_q;
    logic [CW-1:0]   cnt_q;
    logic            decided_q;
    logic            gt_q, lt_q;
    logic            flag_gt_q, flag_eq_q, flag_lt_q;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic            s_gt, s_eq;
    logic            run_gt, run_lt;
    logic            last_slice;
    logic            cmp_exit;
    cmp_result_t     res;

    // Operand registers shift left by CHUNK each CMP cycle, so the slice
    // under test is always the top CHUNK bits. Signed compare inverts both
    // sign bits on slice 0, turning two's-complement into offset-binary.
    always_comb begin
        slice_a = a_q[WIDTH-1 -: CHUNK];
        slice_b = b_q[WIDTH-1 -: CHUNK];
        if (signed_q && cnt_q == '0) begin
            slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
            slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
    end

    cmp_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .gt (s_gt),
        .eq (s_eq)
    );

    // A decision made on an earlier slice is sticky.
    always_comb begin
        run_gt     = decided_q ? gt_q : s_gt;
        run_lt     = decided_q ? lt_q : (!s_gt && !s_eq);
        last_slice = (cnt_q == CW'(NSLICE - 1));
        if (run_gt) begin
            res = CMP_GT;
        end else if (run_lt) begin
            res = CMP_LT;
        end else begin
            res = CMP_EQ;
        end
`ifdef CMP_EARLY_EXIT_EN
        cmp_exit = last_slice || !s_eq;
`else
        cmp_exit = last_slice;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CMP;
            CMP:     if (cmp_exit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            flag_gt_q <= 1'b0;
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= A;
                        b_q       <= B;
                        signed_q  <= is_signed;
                        cnt_q     <= '0;
                        decided_q <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                    end
                end
                CMP: begin
                    a_q       <= a_q << CHUNK;
                    b_q       <= b_q << CHUNK;
                    cnt_q     <= cnt_q + CW'(1);
                    decided_q <= decided_q | !s_eq;
                    gt_q      <= run_gt;
                    lt_q      <= run_lt;
                    if (cmp_exit) begin
                        flag_gt_q <= (res == CMP_GT);
                        flag_eq_q <= (res == CMP_EQ);
                        flag_lt_q <= (res == CMP_LT);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign A_gt_B    = flag_gt_q;
    assign A_eq_B    = flag_eq_q;
    assign A_lt_B    = flag_lt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// -----------------------------------------------------------------------------
// tb_comparator_seq
// Directed bench for comparator_seq: a 16/4 instance for handshake, latency,
// backpressure and reset cases, and a 4/4 instance swept over all operand
// pairs in both signedness modes. Expected flags come from an integer model,
// expected latency from the first differing chunk of A^B.
// -----------------------------------------------------------------------------
module tb_comparator_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid16, in_ready16, sgn16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic        gt16, eq16, lt16, busy16;

    logic        in_valid4, in_ready4, sgn4, out_valid4, out_ready4;
    logic [3:0]  a4, b4;
    logic        gt4, eq4, lt4, busy4;

    comparator_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .is_signed(sgn16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .A_gt_B(gt16), .A_eq_B(eq16), .A_lt_B(lt16), .busy(busy16)
    );

    comparator_seq #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .is_signed(sgn4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .A_gt_B(gt4), .A_eq_B(eq4), .A_lt_B(lt4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // {gt,eq,lt}
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    function automatic logic [2:0] model_cmp(input int unsigned a, input int unsigned b,
                                             input logic s, input int w);
        longint va, vb;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        if (va > vb) return R_GT;
        if (va == vb) return R_EQ;
        return R_LT;
    endfunction

    function automatic int model_lat(input int unsigned a, input int unsigned b,
                                     input int w, input int c);
        int unsigned d;
        d = a ^ b;
        if (EARLY) begin
            for (int i = 0; i < w / c; i++) begin
                if (((d >> (w - (i + 1) * c)) & ((32'd1 << c) - 1)) != 0) return i + 1;
            end
        end
        return w / c;
    endfunction

    logic       exp16_on = 1'b0;
    logic [2:0] exp16    = '0;
    logic       exp4_on  = 1'b0;
    logic [2:0] exp4     = '0;

    // Every cycle: a presented result must match the model and be one-hot;
    // while busy the block must refuse operands.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid16) begin
                if (!exp16_on) chk("mon16_unexpected_result", 1, 0);
                else           chk("mon16_flags", {gt16, eq16, lt16}, exp16);
                chk("mon16_onehot", $countones({gt16, eq16, lt16}), 1);
                chk("mon16_ready_in_done", in_ready16, 0);
            end else if (busy16) begin
                chk("mon16_ready_in_cmp", in_ready16, 0);
            end
            if (out_valid4) begin
                if (!exp4_on) chk("mon4_unexpected_result", 1, 0);
                else          chk("mon4_flags", {gt4, eq4, lt4}, exp4);
                chk("mon4_onehot", $countones({gt4, eq4, lt4}), 1);
            end
        end
    end

    task automatic wait_ready16(input string tag);
        for (int i = 0; i < 20 && !in_ready16; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_in_ready"}, in_ready16, 1);
    endtask

    // lit/lit_lat are hand-computed; hold>0 applies that many cycles of
    // backpressure with a competing operand offer.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [2:0] lit, input int lit_lat,
                         input string tag, input int hold);
        int lat;
        bit seen;
        wait_ready16(tag);
        exp16    = model_cmp(a, b, s, 16);
        exp16_on = 1'b1;
        out_ready16 = (hold == 0);
        in_valid16 = 1'b1; a16 = a; b16 = b; sgn16 = s;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~s;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            seen = out_valid16;
        end
        chk({tag, "_out_valid"}, int'(seen), 1);
        chk({tag, "_latency"}, lat, lit_lat);
        chk({tag, "_latency_model"}, lat, model_lat(a, b, 16, 4));
        chk({tag, "_flags"}, {gt16, eq16, lt16}, lit);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
                @(posedge clk); #1;
                chk({tag, "_bp_out_valid"}, out_valid16, 1);
                chk({tag, "_bp_in_ready"}, in_ready16, 0);
                chk({tag, "_bp_flags"}, {gt16, eq16, lt16}, lit);
            end
            in_valid16 = 1'b0;
            out_ready16 = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_released"}, out_valid16, 0);
        chk({tag, "_idle_ready"}, in_ready16, 1);
        chk({tag, "_flags_kept"}, {gt16, eq16, lt16}, lit);
        exp16_on = 1'b0;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
        bit seen;
        for (int i = 0; i < 20 && !in_ready4; i++) begin
            @(posedge clk); #1;
        end
        exp4    = model_cmp(a, b, s, 4);
        exp4_on = 1'b1;
        in_valid4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = ~a; b4 = ~b;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            seen = out_valid4;
            if (!seen) begin
                @(posedge clk); #1;
                seen = out_valid4;
            end
        end
        chk("x4_out_valid", int'(seen), 1);
        chk("x4_flags", {gt4, eq4, lt4}, exp4);
        @(posedge clk); #1;
        exp4_on = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sgn16 = 1'b0; out_ready16 = 1'b1;
        in_valid4  = 1'b0; a4  = '0; b4  = '0; sgn4  = 1'b0; out_ready4  = 1'b1;
        #12;
        chk("rst_in_ready", in_ready16, 1);
        chk("rst_out_valid", out_valid16, 0);
        chk("rst_flags", {gt16, eq16, lt16}, 0);
        chk("rst_busy", busy16, 0);
        chk("rst4_flags", {gt4, eq4, lt4}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run16(16'h1234, 16'h1234, 1'b0, R_EQ, 4, "eq_1234", 0);
        run16(16'h8000, 16'h7FFF, 1'b0, R_GT, EARLY ? 1 : 4, "u_8000_7fff", 0);
        run16(16'h8000, 16'h7FFF, 1'b1, R_LT, EARLY ? 1 : 4, "s_8000_7fff", 0);
        run16(16'hFFFF, 16'h0000, 1'b1, R_LT, EARLY ? 1 : 4, "s_ffff_0000", 0);
        run16(16'hFFFF, 16'h0000, 1'b0, R_GT, EARLY ? 1 : 4, "u_ffff_0000", 0);
        run16(16'h5000, 16'h4FFF, 1'b0, R_GT, EARLY ? 1 : 4, "u_5000_4fff", 0);
        run16(16'h1235, 16'h1234, 1'b0, R_GT, 4, "u_1235_1234", 0);
        run16(16'h0010, 16'h0020, 1'b1, R_LT, EARLY ? 3 : 4, "s_0010_0020", 0);
        run16(16'h7000, 16'h7001, 1'b1, R_LT, 4, "bp_7000_7001", 3);

        // Abort a compare at cnt=2; no result may appear afterwards.
        wait_ready16("rst_mid");
        exp16_on = 1'b0;
        in_valid16 = 1'b1; a16 = 16'h1235; b16 = 16'h1234; sgn16 = 1'b0;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_busy_before", busy16, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid16, 0);
        chk("rst_mid_flags", {gt16, eq16, lt16}, 0);
        chk("rst_mid_busy", busy16, 0);
        chk("rst_mid_in_ready", in_ready16, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_result", out_valid16, 0);
        end
        run16(16'h0001, 16'hFFFF, 1'b1, R_GT, EARLY ? 1 : 4, "after_rst", 0);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run4(4'(a), 4'(b), 1'(s));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
